// File: rtl/core_pkg.sv
// Constants and types shared by the fetch path: program counter, branch-target LUT
// and instruction memory.
package core_pkg;

    localparam int unsigned PC_W       = 10;
    localparam int unsigned START_ADDR = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones instead of wrapping.
// A synchronous clear takes priority over the enable.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_d;
    logic             w_at_max;

    assign w_at_max = (r_count == {WIDTH{1'b1}});

    always_comb begin
        w_count_d = r_count;
        if (i_clr) begin
            w_count_d = '0;
        end else if (i_en && !w_at_max) begin
            w_count_d = r_count + WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        r_count <= w_count_d;
    end

    assign o_count = r_count;

endmodule

// File: rtl/prog_ctr_unit.sv
// Program counter and fetch sequencer: Start/Done handshake, stall, absolute
// branches, sequential advance with sticky wrap flag, and a per-run cycle count.
module prog_ctr_unit #(
    parameter int unsigned PC_W       = core_pkg::PC_W,
    parameter int unsigned START_ADDR = core_pkg::START_ADDR,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             Stall,
    input  logic             BranchEn,
    input  logic             Taken,
    input  logic [PC_W-1:0]  Target,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Busy,
    output logic             Done,
    output logic             Wrapped,
    output logic [CNT_W-1:0] CycleCount
);

    import core_pkg::*;

    localparam logic [PC_W-1:0] StartPc = PC_W'(START_ADDR);

    pc_state_t       r_state;
    pc_state_t       w_state_d;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_d;
    logic            r_wrapped;
    logic            w_wrapped_d;
    logic            w_cnt_clr;
    logic            w_cnt_en;

    always_comb begin
        w_state_d   = r_state;
        w_pc_d      = r_pc;
        w_wrapped_d = r_wrapped;
        w_cnt_clr   = 1'b0;
        w_cnt_en    = 1'b0;
        unique case (r_state)
            IDLE, HALTED: begin
                if (Start) begin
                    w_state_d   = RUN;
                    w_pc_d      = StartPc;
                    w_wrapped_d = 1'b0;
                    w_cnt_clr   = 1'b1;
                end
            end
            RUN: begin
                // Every RUN edge counts, including stalls and the edge into HALTED.
                w_cnt_en = 1'b1;
                if (Halt) begin
                    w_state_d = HALTED;
                end else if (Stall) begin
                    w_pc_d = r_pc;
                end else if (BranchEn && Taken) begin
                    w_pc_d = Target;
                end else begin
                    w_pc_d = r_pc + PC_W'(1);
                    if (r_pc == {PC_W{1'b1}}) begin
                        w_wrapped_d = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_pc      <= '0;
            r_wrapped <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_pc      <= w_pc_d;
            r_wrapped <= w_wrapped_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_cnt (
        .i_clk   (Clk),
        .i_clr   (Reset | w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (CycleCount)
    );

    assign ProgCtr = r_pc;
    assign Wrapped = r_wrapped;
    assign Busy    = (r_state == RUN);
    assign Done    = (r_state == HALTED);

endmodule

// File: tb/tb_prog_ctr_unit.sv
// Directed bench for prog_ctr_unit: each step drives one cycle of inputs, queues the
// expected post-edge outputs and compares them just after the rising edge.
module tb_prog_ctr_unit;

    localparam int unsigned PC_W  = 10;
    localparam int unsigned CNT_W = 16;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             Start;
    logic             Halt;
    logic             Stall;
    logic             BranchEn;
    logic             Taken;
    logic [PC_W-1:0]  Target;
    logic [PC_W-1:0]  ProgCtr;
    logic             Busy;
    logic             Done;
    logic             Wrapped;
    logic [CNT_W-1:0] CycleCount;

    typedef struct packed {
        logic [PC_W-1:0]  pc;
        logic             busy;
        logic             done;
        logic             wrapped;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t q_exp[$];
    int   n_pass  = 0;
    int   n_total = 0;
    int   step_no = 0;

    prog_ctr_unit #(
        .PC_W       (PC_W),
        .START_ADDR (0),
        .CNT_W      (CNT_W)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Start      (Start),
        .Halt       (Halt),
        .Stall      (Stall),
        .BranchEn   (BranchEn),
        .Taken      (Taken),
        .Target     (Target),
        .ProgCtr    (ProgCtr),
        .Busy       (Busy),
        .Done       (Done),
        .Wrapped    (Wrapped),
        .CycleCount (CycleCount)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s step %0d: got %0d, expected %0d", tag, step_no, obs, exp);
    endtask

    task automatic drive(input logic rst, input logic st, input logic ht, input logic sl,
                         input logic be, input logic tk, input int tgt);
        Reset    = rst;
        Start    = st;
        Halt     = ht;
        Stall    = sl;
        BranchEn = be;
        Taken    = tk;
        Target   = PC_W'(tgt);
    endtask

    task automatic step(input logic rst, input logic st, input logic ht, input logic sl,
                        input logic be, input logic tk, input int tgt,
                        input int e_pc, input logic e_busy, input logic e_done,
                        input logic e_wr, input int e_cnt);
        exp_t e;
        exp_t got;
        drive(rst, st, ht, sl, be, tk, tgt);
        e.pc      = PC_W'(e_pc);
        e.busy    = e_busy;
        e.done    = e_done;
        e.wrapped = e_wr;
        e.cnt     = CNT_W'(e_cnt);
        q_exp.push_back(e);
        @(posedge Clk);
        #1;
        step_no++;
        got = q_exp.pop_front();
        check("ProgCtr",    32'(ProgCtr),    32'(got.pc));
        check("Busy",       32'(Busy),       32'(got.busy));
        check("Done",       32'(Done),       32'(got.done));
        check("Wrapped",    32'(Wrapped),    32'(got.wrapped));
        check("CycleCount", 32'(CycleCount), 32'(got.cnt));
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        //   rst st ht sl be tk tgt   pc  busy done wr cnt
        step(1, 0, 0, 0, 0, 0, 0,      0,   0,  0,  0, 0);
        step(1, 0, 0, 0, 0, 0, 0,      0,   0,  0,  0, 0);
        step(0, 1, 0, 0, 0, 0, 0,      0,   1,  0,  0, 0);
        step(0, 0, 0, 0, 0, 0, 0,      1,   1,  0,  0, 1);
        step(0, 0, 0, 0, 0, 0, 0,      2,   1,  0,  0, 2);
        step(0, 0, 0, 0, 0, 0, 0,      3,   1,  0,  0, 3);
        // Taken and not-taken branches from ProgCtr=5
        step(0, 0, 0, 0, 1, 1, 5,      5,   1,  0,  0, 4);
        step(0, 0, 0, 0, 1, 1, 126,    126, 1,  0,  0, 5);
        step(0, 0, 0, 0, 1, 1, 5,      5,   1,  0,  0, 6);
        step(0, 0, 0, 0, 1, 0, 126,    6,   1,  0,  0, 7);
        // Stalls at 40, then stall beats a taken branch
        step(0, 0, 0, 0, 1, 1, 40,     40,  1,  0,  0, 8);
        step(0, 0, 0, 1, 0, 0, 0,      40,  1,  0,  0, 9);
        step(0, 0, 0, 1, 0, 0, 0,      40,  1,  0,  0, 10);
        step(0, 0, 0, 1, 0, 0, 0,      40,  1,  0,  0, 11);
        step(0, 0, 0, 1, 1, 1, 217,    40,  1,  0,  0, 12);
        // Halt at 90, idle in HALTED, restart
        step(0, 0, 0, 0, 1, 1, 90,     90,  1,  0,  0, 13);
        step(0, 0, 1, 0, 1, 1, 300,    90,  0,  1,  0, 14);
        step(0, 0, 0, 1, 1, 1, 300,    90,  0,  1,  0, 14);
        step(0, 1, 0, 0, 0, 0, 0,      0,   1,  0,  0, 0);
        // Wrap past all-ones
        step(0, 0, 0, 0, 1, 1, 1022,   1022, 1, 0,  0, 1);
        step(0, 0, 0, 0, 0, 0, 0,      1023, 1, 0,  0, 2);
        step(0, 0, 0, 0, 0, 0, 0,      0,   1,  0,  1, 3);
        step(0, 0, 0, 0, 0, 0, 0,      1,   1,  0,  1, 4);
        step(0, 0, 1, 0, 0, 0, 0,      1,   0,  1,  1, 5);
        step(0, 1, 0, 0, 0, 0, 0,      0,   1,  0,  0, 0);
        // Start in RUN ignored; reset mid-run at 146
        step(0, 1, 0, 0, 0, 0, 0,      1,   1,  0,  0, 1);
        step(0, 0, 0, 0, 1, 1, 146,    146, 1,  0,  0, 2);
        step(1, 1, 1, 0, 1, 1, 7,      0,   0,  0,  0, 0);
        step(0, 0, 1, 1, 1, 1, 7,      0,   0,  0,  0, 0);
        // Halt and Start together in RUN: Halt wins
        step(0, 1, 0, 0, 0, 0, 0,      0,   1,  0,  0, 0);
        step(0, 1, 1, 0, 0, 0, 0,      0,   0,  1,  0, 1);
        step(0, 0, 0, 0, 0, 0, 0,      0,   0,  1,  0, 1);
        // CycleCount saturation: stall long enough to reach all-ones
        step(0, 1, 0, 0, 0, 0, 0,      0,   1,  0,  0, 0);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        repeat (65534) @(posedge Clk);
        #1;
        step(0, 0, 0, 1, 0, 0, 0,      0,   1,  0,  0, 65535);
        step(0, 0, 0, 1, 0, 0, 0,      0,   1,  0,  0, 65535);
        step(0, 0, 1, 0, 0, 0, 0,      0,   0,  1,  0, 65535);
        step(0, 0, 0, 0, 0, 0, 0,      0,   0,  1,  0, 65535);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
